// File: rtl/mdf_pipe_mul_if.sv
// Handshake/data bundle for the pipelined multiplier: op in, tagged result out.
// The slave modport is the multiplier's view; master is the issuing/consuming side.
interface mdf_pipe_mul_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

  modport master (
    output in_valid, in_mode, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mdf_pipe_mul.sv
// Fully pipelined tagged multiplier: partial products on magnitudes, pairwise adder
// tree, sign fix-up and half select in the last stage. Whole pipe freezes on stall.
module mdf_pipe_mul #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           nRST,
  input  logic           flush,
  mdf_pipe_mul_if.slave  bus
);
  localparam int unsigned LAT = 1 + $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULH   = 2'b01,
    MODE_MULHU  = 2'b10,
    MODE_MULHSU = 2'b11
  } mode_e;

  // Stage s (1..LAT-1) holds WIDTH>>(s-1) live partial sums; the rest stay zero.
  logic [PW-1:0]    pp_q    [1:LAT-1][WIDTH];
  logic             valid_q [1:LAT-1];
  logic             neg_q   [1:LAT-1];
  mode_e            mode_q  [1:LAT-1];
  logic [TAG_W-1:0] tag_q   [1:LAT-1];

  logic             stall;
  mode_e            in_mode;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    pp_next [WIDTH];
  logic [PW-1:0]    sum;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] final_result;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign in_mode      = mode_e'(bus.in_mode);

  // Operand A is signed in MULH and MULHSU, operand B only in MULH.
  always_comb begin
    sign_a = ((in_mode == MODE_MULH) || (in_mode == MODE_MULHSU)) & bus.in_a[WIDTH-1];
    sign_b = (in_mode == MODE_MULH) & bus.in_b[WIDTH-1];
    mag_a  = sign_a ? -bus.in_a : bus.in_a;
    mag_b  = sign_b ? -bus.in_b : bus.in_b;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp_next[i] = mag_b[i] ? ({{WIDTH{1'b0}}, mag_a} << i) : '0;
    end
  end

  always_comb begin
    sum          = pp_q[LAT-1][0] + pp_q[LAT-1][1];
    prod         = neg_q[LAT-1] ? -sum : sum;
    final_result = (mode_q[LAT-1] == MODE_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned s = 1; s < LAT; s++) begin
        valid_q[s] <= 1'b0;
        neg_q[s]   <= 1'b0;
        mode_q[s]  <= MODE_MUL;
        tag_q[s]   <= '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
          pp_q[s][j] <= '0;
        end
      end
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
    end else begin
      if (flush) begin
        for (int unsigned s = 1; s < LAT; s++) begin
          valid_q[s] <= 1'b0;
        end
        bus.out_valid <= 1'b0;
      end else if (!stall) begin
        valid_q[1] <= bus.in_valid;
        for (int unsigned s = 2; s < LAT; s++) begin
          valid_q[s] <= valid_q[s-1];
        end
        bus.out_valid <= valid_q[LAT-1];
      end

      // Data only moves behind a valid op, so bubbles keep old contents.
      if (!stall) begin
        if (bus.in_valid) begin
          neg_q[1]  <= sign_a ^ sign_b;
          mode_q[1] <= in_mode;
          tag_q[1]  <= bus.in_tag;
          for (int unsigned j = 0; j < WIDTH; j++) begin
            pp_q[1][j] <= pp_next[j];
          end
        end
        for (int unsigned s = 2; s < LAT; s++) begin
          if (valid_q[s-1]) begin
            neg_q[s]  <= neg_q[s-1];
            mode_q[s] <= mode_q[s-1];
            tag_q[s]  <= tag_q[s-1];
            for (int unsigned j = 0; j < (WIDTH >> (s - 1)); j++) begin
              pp_q[s][j] <= pp_q[s-1][2*j] + pp_q[s-1][2*j+1];
            end
          end
        end
        if (valid_q[LAT-1]) begin
          bus.out_result <= final_result;
          bus.out_tag    <= tag_q[LAT-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_mdf_pipe_mul.sv
// Directed + scoreboard bench for mdf_pipe_mul at WIDTH=32 (LAT=6) and WIDTH=8 (LAT=4).
module tb_mdf_pipe_mul;
  localparam int LAT32 = 6;
  localparam int LAT8  = 4;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic nRST;
  logic flush32;
  logic flush8;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;

  mdf_pipe_mul_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
  mdf_pipe_mul_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

  mdf_pipe_mul #(.WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .nRST(nRST), .flush(flush32), .bus(bus32.slave)
  );
  mdf_pipe_mul #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .nRST(nRST), .flush(flush8), .bus(bus8.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: extend each operand per mode to 64 bits, multiply, pick the half.
  function automatic logic [63:0] model(input int unsigned w, input logic [1:0] m,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb, p, mask;
    mask = (64'd1 << w) - 64'd1;
    ea   = a & mask;
    eb   = b & mask;
    if ((m == 2'b01 || m == 2'b11) && ea[w-1]) ea = ea | ~mask;
    if (m == 2'b01 && eb[w-1]) eb = eb | ~mask;
    p = ea * eb;
    return (m == 2'b00) ? (p & mask) : ((p >> w) & mask);
  endfunction

  always @(negedge clk) begin
    if (!nRST) begin
      q32.delete();
    end else begin
      if (bus32.out_valid && bus32.out_ready) begin
        if (q32.size() == 0) begin
          check("sb32_extra", 64'(bus32.out_valid), 64'd0);
        end else begin
          e32 = q32.pop_front();
          check("sb32_res", 64'(bus32.out_result), e32.res);
          check("sb32_tag", 64'(bus32.out_tag), 64'(e32.tag));
        end
      end
      if (flush32) q32.delete();
      else if (bus32.in_valid && bus32.in_ready)
        q32.push_back('{res: model(32, bus32.in_mode, 64'(bus32.in_a), 64'(bus32.in_b)),
                        tag: bus32.in_tag});
    end
  end

  always @(negedge clk) begin
    if (!nRST) begin
      q8.delete();
    end else begin
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) begin
          check("sb8_extra", 64'(bus8.out_valid), 64'd0);
        end else begin
          e8 = q8.pop_front();
          check("sb8_res", 64'(bus8.out_result), e8.res);
          check("sb8_tag", 64'(bus8.out_tag), 64'(e8.tag));
        end
      end
      if (flush8) q8.delete();
      else if (bus8.in_valid && bus8.in_ready)
        q8.push_back('{res: model(8, bus8.in_mode, 64'(bus8.in_a), 64'(bus8.in_b)),
                       tag: bus8.in_tag});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
    bus32.in_valid = 1'b1;
    bus32.in_mode  = m;
    bus32.in_a     = a;
    bus32.in_b     = b;
    bus32.in_tag   = t;
  endtask

  task automatic single32(input string nm, input logic [1:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t, input logic [31:0] exp);
    int n;
    drive32(m, a, b, t);
    step();
    bus32.in_valid = 1'b0;
    n = 0;
    while (!bus32.out_valid && n < 20) begin
      step();
      n++;
    end
    check({nm, "_lat"}, 64'(n), 64'(LAT32 - 1));
    check({nm, "_res"}, 64'(bus32.out_result), 64'(exp));
    check({nm, "_tag"}, 64'(bus32.out_tag), 64'(t));
    step();
  endtask

  task automatic single8(input string nm, input logic [1:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] t, input logic [7:0] exp);
    int n;
    bus8.in_valid = 1'b1;
    bus8.in_mode  = m;
    bus8.in_a     = a;
    bus8.in_b     = b;
    bus8.in_tag   = t;
    step();
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      step();
      n++;
    end
    check({nm, "_lat"}, 64'(n), 64'(LAT8 - 1));
    check({nm, "_res"}, 64'(bus8.out_result), 64'(exp));
    check({nm, "_tag"}, 64'(bus8.out_tag), 64'(t));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] a3 [8] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678,
                          32'd100, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'hDEAD_BEEF};
  logic [31:0] b3 [8] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0010,
                          32'hFFFF_FFFE, 32'd7, 32'h7FFF_FFFF, 32'hCAFE_F00D};

  initial begin
    int got_tags[$];
    int first, last, n, seen, tagk;
    logic [31:0] r_hold;
    logic [3:0]  t_hold;

    nRST = 1'b0; flush32 = 1'b0; flush8 = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_mode = 2'b00; bus32.in_a = '0; bus32.in_b = '0;
    bus32.in_tag = '0; bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_mode = 2'b00; bus8.in_a = '0; bus8.in_b = '0;
    bus8.in_tag = '0; bus8.out_ready = 1'b1;
    step(); step();
    check("rst_ov32",  64'(bus32.out_valid),  64'd0);
    check("rst_res32", 64'(bus32.out_result), 64'd0);
    check("rst_tag32", 64'(bus32.out_tag),    64'd0);
    check("rst_ov8",   64'(bus8.out_valid),   64'd0);
    nRST = 1'b1;
    step();
    check("rst_rdy32", 64'(bus32.in_ready), 64'd1);

    // Basic latency and the signed/unsigned corner cases.
    single32("t1_mul",    2'b00, 32'd7,          32'd6,          4'h5, 32'd42);
    single32("t2_mulh",   2'b01, 32'hFFFF_FFFD,  32'd5,          4'h1, 32'hFFFF_FFFF);
    single32("t2_mulhu",  2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'h2, 32'hFFFF_FFFE);
    single32("t2_mulhsu", 2'b11, 32'hFFFF_FFFF,  32'd2,          4'h3, 32'hFFFF_FFFF);
    single32("t2_mul_lo", 2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'h4, 32'd1);
    single32("t2_mulh_mn",2'b01, 32'h8000_0000,  32'h8000_0000,  4'h6, 32'h4000_0000);
    single32("t2_hsu_mn", 2'b11, 32'h8000_0000,  32'h8000_0000,  4'h7, 32'hC000_0000);

    // Eight back-to-back ops: results contiguous and in issue order.
    first = -1; last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus32.out_valid) begin
        got_tags.push_back(int'(bus32.out_tag));
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (cyc < 8) drive32(2'(cyc % 4), a3[cyc], b3[cyc], 4'(cyc));
      else bus32.in_valid = 1'b0;
      step();
    end
    check("t3_count", 64'(got_tags.size()), 64'd8);
    check("t3_span",  64'(last - first), 64'd7);
    for (int k = 0; k < got_tags.size(); k++) check("t3_order", 64'(got_tags[k]), 64'(k));

    // Fill, then hold out_ready low for three edges.
    tagk = 8; n = 0;
    while (!bus32.out_valid && n < 20) begin
      drive32(2'(tagk % 4), 32'd1000 + 32'(tagk), 32'hFFFF_0000 + 32'(tagk), 4'(tagk));
      step();
      tagk++; n++;
    end
    check("t4_fill", 64'(bus32.out_valid), 64'd1);
    drive32(2'b01, 32'hFFFF_FF00, 32'd77, 4'(tagk));
    bus32.out_ready = 1'b0;
    #1;
    check("t4_in_ready", 64'(bus32.in_ready), 64'd0);
    r_hold = bus32.out_result;
    t_hold = bus32.out_tag;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_ov_hold",  64'(bus32.out_valid),  64'd1);
      check("t4_res_hold", 64'(bus32.out_result), 64'(r_hold));
      check("t4_tag_hold", 64'(bus32.out_tag),    64'(t_hold));
      check("t4_rdy_low",  64'(bus32.in_ready),   64'd0);
    end
    bus32.out_ready = 1'b1;
    step();
    drive32(2'b10, 32'hABCD_0001, 32'h0000_0003, 4'hE);
    step();
    bus32.in_valid = 1'b0;
    n = 0;
    while ((q32.size() != 0 || bus32.out_valid) && n < 30) begin
      step();
      n++;
    end
    check("t4_drain", 64'(q32.size()), 64'd0);

    // Four in flight, then flush with a fifth op offered.
    for (int k = 0; k < 4; k++) begin
      drive32(2'b00, 32'd11 + 32'(k), 32'd13, 4'(k + 1));
      step();
    end
    drive32(2'b00, 32'd5, 32'd5, 4'h5);
    flush32 = 1'b1;
    step();
    check("t5_flush_ov", 64'(bus32.out_valid), 64'd0);
    flush32 = 1'b0;
    bus32.in_valid = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (bus32.out_valid) seen++;
    end
    check("t5_ghost", 64'(seen), 64'd0);
    single32("t5_after", 2'b00, 32'd12, 32'd12, 4'h9, 32'd144);

    // Async reset mid-stream.
    n = 0;
    while (!bus32.out_valid && n < 20) begin
      drive32(2'b00, 32'd3 + 32'(n), 32'd9, 4'hA);
      step();
      n++;
    end
    #3;
    nRST = 1'b0;
    bus32.in_valid = 1'b0;
    #1;
    check("t6_ov_rst",  64'(bus32.out_valid),  64'd0);
    check("t6_res_rst", 64'(bus32.out_result), 64'd0);
    check("t6_tag_rst", 64'(bus32.out_tag),    64'd0);
    step(); step();
    nRST = 1'b1;
    step();
    single32("t6_cold", 2'b00, 32'd9, 32'd9, 4'h3, 32'd81);

    // WIDTH=8 regression.
    single8("t6_w8", 2'b01, 8'h80, 8'h80, 4'h2, 8'h40);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus8.in_valid  = ($urandom_range(0, 3) != 0);
      bus8.in_mode   = 2'($urandom_range(0, 3));
      bus8.in_a      = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      bus8.in_b      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      bus8.in_tag    = 4'($urandom);
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      flush8         = ($urandom_range(0, 39) == 0);
      step();
    end
    flush8 = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    n = 0;
    while ((q8.size() != 0 || bus8.out_valid) && n < 30) begin
      step();
      n++;
    end
    check("r8_drain",  64'(q8.size()),  64'd0);
    check("end_q32",   64'(q32.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
